// File: rtl/flash_audio_streamer.sv
// Streams audio samples out of an Avalon-MM flash: one single-beat read per word,
// then one sample slice per sample_tick, forward or reverse, with optional looping.
module flash_audio_streamer #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  direction_i,
    input  logic                  loop_en_i,
    input  logic [ADDR_W-1:0]     start_addr_i,
    input  logic [ADDR_W-1:0]     end_addr_i,
    input  logic                  sample_tick_i,
    input  logic                  flash_mem_waitrequest_i,
    input  logic                  flash_mem_readdatavalid_i,
    input  logic [DATA_W-1:0]     flash_mem_readdata_i,
    output logic                  flash_mem_read_o,
    output logic [ADDR_W-1:0]     flash_mem_address_o,
    output logic                  flash_mem_write_o,
    output logic [DATA_W-1:0]     flash_mem_writedata_o,
    output logic [5:0]            flash_mem_burstcount_o,
    output logic [DATA_W/8-1:0]   flash_mem_byteenable_o,
    output logic [SAMPLE_W-1:0]   audio_out_o,
    output logic                  audio_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  underrun_o
);

    localparam int N     = DATA_W / SAMPLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_EMIT      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    start_addr_q, start_addr_d;
    logic [ADDR_W-1:0]    end_addr_q, end_addr_d;
    logic                 dir_q, dir_d;
    logic                 loop_q, loop_d;
    logic [DATA_W-1:0]    word_buf_q, word_buf_d;
    logic [IDX_W-1:0]     slice_q, slice_d;
    logic [SAMPLE_W-1:0]  audio_q, audio_d;
    logic                 audio_valid_q, audio_valid_d;
    logic                 underrun_q, underrun_d;
    logic                 abort_pend_q, abort_pend_d;

    logic [IDX_W-1:0]     last_idx_s;
    logic [ADDR_W-1:0]    term_addr_s;
    logic [ADDR_W-1:0]    reload_addr_s;
    logic [ADDR_W-1:0]    step_addr_s;

    function automatic logic [SAMPLE_W-1:0] slice_of(input logic [DATA_W-1:0] w,
                                                      input logic [IDX_W-1:0]  k);
        logic [DATA_W-1:0] sh;
        sh = w >> (int'(k) * SAMPLE_W);
        return sh[SAMPLE_W-1:0];
    endfunction

    // Direction-dependent end points; reverse playback walks end_addr down to start_addr.
    assign last_idx_s    = dir_q ? ZERO_IDX : LAST_IDX;
    assign term_addr_s   = dir_q ? start_addr_q : end_addr_q;
    assign reload_addr_s = dir_q ? end_addr_q : start_addr_q;
    assign step_addr_s   = dir_q ? (addr_q - ONE_ADDR) : (addr_q + ONE_ADDR);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= {ADDR_W{1'b0}};
            start_addr_q  <= {ADDR_W{1'b0}};
            end_addr_q    <= {ADDR_W{1'b0}};
            dir_q         <= 1'b0;
            loop_q        <= 1'b0;
            word_buf_q    <= {DATA_W{1'b0}};
            slice_q       <= {IDX_W{1'b0}};
            audio_q       <= {SAMPLE_W{1'b0}};
            audio_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            abort_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            start_addr_q  <= start_addr_d;
            end_addr_q    <= end_addr_d;
            dir_q         <= dir_d;
            loop_q        <= loop_d;
            word_buf_q    <= word_buf_d;
            slice_q       <= slice_d;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
            underrun_q    <= underrun_d;
            abort_pend_q  <= abort_pend_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        start_addr_d  = start_addr_q;
        end_addr_d    = end_addr_q;
        dir_d         = dir_q;
        loop_d        = loop_q;
        word_buf_d    = word_buf_q;
        slice_d       = slice_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        underrun_d    = underrun_q;
        abort_pend_d  = abort_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_addr_d = start_addr_i;
                    end_addr_d   = end_addr_i;
                    dir_d        = direction_i;
                    loop_d       = loop_en_i;
                    addr_d       = direction_i ? end_addr_i : start_addr_i;
                    underrun_d   = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = ST_REQ;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_REQ: begin
                underrun_d   = underrun_q | sample_tick_i;
                abort_pend_d = abort_pend_q | abort_i;
                if (!flash_mem_waitrequest_i) begin
                    state_d = ST_WAIT_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT_DATA: begin
                underrun_d = underrun_q | sample_tick_i;
                // An abort must still let the outstanding read finish before leaving.
                if (flash_mem_readdatavalid_i) begin
                    if (abort_pend_q || abort_i) begin
                        abort_pend_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        word_buf_d = flash_mem_readdata_i;
                        slice_d    = dir_q ? LAST_IDX : ZERO_IDX;
                        state_d    = ST_EMIT;
                    end
                end else begin
                    abort_pend_d = abort_pend_q | abort_i;
                end
            end
            ST_EMIT: begin
                if (sample_tick_i) begin
                    audio_d       = slice_of(word_buf_q, slice_q);
                    audio_valid_d = 1'b1;
                    if (slice_q == last_idx_s) begin
                        if (addr_q == term_addr_s) begin
                            if (loop_q) begin
                                addr_d  = reload_addr_s;
                                state_d = ST_REQ;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            addr_d  = step_addr_s;
                            state_d = ST_REQ;
                        end
                    end else begin
                        slice_d = dir_q ? (slice_q - ONE_IDX) : (slice_q + ONE_IDX);
                    end
                end else begin
                    slice_d = slice_q;
                end
                // Abort takes priority over any word or range completion.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    abort_pend_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign flash_mem_read_o       = (state_q == ST_REQ);
    assign flash_mem_address_o    = addr_q;
    assign flash_mem_write_o      = 1'b0;
    assign flash_mem_writedata_o  = {DATA_W{1'b0}};
    assign flash_mem_burstcount_o = 6'd1;
    assign flash_mem_byteenable_o = {(DATA_W/8){1'b1}};
    assign audio_out_o            = audio_q;
    assign audio_valid_o          = audio_valid_q;
    assign busy_o                 = (state_q != ST_IDLE);
    assign done_o                 = (state_q == ST_DONE);
    assign underrun_o             = underrun_q;

endmodule

// File: tb/tb_flash_audio_streamer.sv
// Bench for flash_audio_streamer: directed scenarios plus randomized traffic, all
// checked every cycle against a playback-level model (word index / sample count).
module tb_flash_audio_streamer;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int N  = DW / SW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, dir, loop_en, tick, wr, rdv;
    logic [AW-1:0] sa, ea;
    logic [DW-1:0] rdata;
    logic          read_o, write_o, valid_o, busy_o, done_o, under_o;
    logic [AW-1:0] address_o;
    logic [DW-1:0] wdata_o;
    logic [5:0]    burst_o;
    logic [3:0]    be_o;
    logic [SW-1:0] audio_o;

    flash_audio_streamer #(.ADDR_W(AW), .DATA_W(DW), .SAMPLE_W(SW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .direction_i(dir), .loop_en_i(loop_en),
        .start_addr_i(sa), .end_addr_i(ea), .sample_tick_i(tick),
        .flash_mem_waitrequest_i(wr), .flash_mem_readdatavalid_i(rdv),
        .flash_mem_readdata_i(rdata),
        .flash_mem_read_o(read_o), .flash_mem_address_o(address_o),
        .flash_mem_write_o(write_o), .flash_mem_writedata_o(wdata_o),
        .flash_mem_burstcount_o(burst_o), .flash_mem_byteenable_o(be_o),
        .audio_out_o(audio_o), .audio_valid_o(valid_o), .busy_o(busy_o),
        .done_o(done_o), .underrun_o(under_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Playback model: phase 0 idle, 1 requesting, 2 awaiting data, 3 playing word, 4 finished.
    int            m_ph;
    logic [AW-1:0] m_sa, m_ea;
    bit            m_dir, m_loop, m_valid, m_under, m_pend;
    longint        m_word;
    int            m_k;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_audio;

    // Flash slave and logs
    int            resp_cnt = 0;
    logic [DW-1:0] resp_data;
    int            wr_hold = 0;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            rand_wr = 1'b0;
    int            rd_cycles = 0;
    int            done_cnt = 0;
    int            valid_cnt = 0;
    logic [AW-1:0] addr_log[$];
    logic [SW-1:0] samp_log[$];

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == 23'h000010) return 32'hBBBBAAAA;
        else if (a == 23'h000011) return 32'hDDDDCCCC;
        else return ({9'd0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic longint range_len();
        logic [AW-1:0] d;
        d = m_ea - m_sa;
        return longint'(d) + 1;
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        longint        idx;
        logic [AW-1:0] off;
        idx = m_word % range_len();
        off = AW'(idx);
        if (m_dir) return m_ea - off;
        else return m_sa + off;
    endfunction

    function automatic logic [SW-1:0] sample_of(input int k);
        int            s;
        logic [DW-1:0] sh;
        s  = m_dir ? (N - 1 - k) : k;
        sh = m_data >> (s * SW);
        return sh[SW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_ph = 0; m_sa = '0; m_ea = '0; m_dir = 0; m_loop = 0; m_word = 0; m_k = 0;
            m_data = '0; m_audio = '0; m_valid = 0; m_under = 0; m_pend = 0;
            return;
        end
        m_valid = 0;
        case (m_ph)
            0: if (start) begin
                m_sa = sa; m_ea = ea; m_dir = dir; m_loop = loop_en;
                m_word = 0; m_under = 0; m_pend = 0; m_ph = 1;
            end
            1: begin
                if (tick) m_under = 1;
                if (abort) m_pend = 1;
                if (!wr) m_ph = 2;
            end
            2: begin
                if (tick) m_under = 1;
                if (rdv) begin
                    if (m_pend || abort) begin m_ph = 0; m_pend = 0; end
                    else begin m_data = rdata; m_k = 0; m_ph = 3; end
                end else if (abort) m_pend = 1;
            end
            3: begin
                if (tick) begin
                    m_audio = sample_of(m_k);
                    m_valid = 1;
                    m_k++;
                    if (m_k == N) begin
                        if (!m_loop && m_word == range_len() - 1) m_ph = 4;
                        else begin m_word++; m_ph = 1; end
                    end
                end
                if (abort) m_ph = 0;
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic slave_drive();
        rdv   = 1'b0;
        rdata = $urandom;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin rdv = 1'b1; rdata = resp_data; end
        end
        if (read_o) begin
            rd_cycles++;
            if (wr_hold > 0) begin wr = 1'b1; wr_hold--; end
            else if (rand_wr && $urandom_range(0, 2) == 0) wr = 1'b1;
            else begin
                wr = 1'b0;
                addr_log.push_back(address_o);
                resp_cnt  = $urandom_range(lat_min, lat_max);
                resp_data = mem(address_o);
            end
        end else begin
            wr = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic tick_cycle(input bit st, input bit ab, input bit tk, input bit rs);
        @(negedge clk);
        start = st; abort = ab; tick = tk; rst = rs;
        slave_drive();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit d, input bit l);
        sa = s; ea = e; dir = d; loop_en = l;
        tick_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to_idle(input int period, input int maxc);
        int c;
        c = 0;
        while (c < maxc) begin
            tick_cycle(1'b0, 1'b0, (c % period) == period - 1, 1'b0);
            c++;
            if (!busy_o) break;
        end
        chk("idle_within_budget", 32'(busy_o), 32'h0);
    endtask

    task automatic wait_accept(input int want, input int maxc);
        int c;
        c = 0;
        while (addr_log.size() < want && c < maxc) begin
            tick_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            c++;
        end
        chk("read_accepted", 32'(addr_log.size() >= want), 32'h1);
    endtask

    task automatic clear_logs();
        addr_log.delete(); samp_log.delete();
        done_cnt = 0; valid_cnt = 0; rd_cycles = 0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy", 32'(busy_o), 32'(m_ph != 0));
            chk("done", 32'(done_o), 32'(m_ph == 4));
            chk("read", 32'(read_o), 32'(m_ph == 1));
            chk("audio_valid", 32'(valid_o), 32'(m_valid));
            chk("audio_out", 32'(audio_o), 32'(m_audio));
            chk("underrun", 32'(under_o), 32'(m_under));
            chk("const_outs", {write_o, wdata_o[0], burst_o, be_o}, {1'b0, 1'b0, 6'd1, 4'hF});
            if (m_ph == 1) chk("address", 32'(address_o), 32'(exp_addr()));
        end
        if (valid_o) begin samp_log.push_back(audio_o); valid_cnt++; end
        if (done_o) done_cnt++;
    end

    initial begin
        logic [SW-1:0] a_before;
        bit st, ab, tk, rs;
        rst = 1'b1; start = 0; abort = 0; dir = 0; loop_en = 0; tick = 0;
        wr = 0; rdv = 0; rdata = '0; sa = '0; ea = '0;
        tick_cycle(0, 0, 0, 1);
        chk_en = 1'b1;
        tick_cycle(0, 0, 0, 1);
        tick_cycle(0, 0, 0, 0);
        chk("reset_audio", 32'(audio_o), 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_underrun", 32'(under_o), 32'h0);

        // Forward two-word playback
        clear_logs();
        do_start(23'h10, 23'h11, 0, 0);
        run_to_idle(8, 200);
        chk("fwd_nreads", 32'(addr_log.size()), 32'd2);
        chk("fwd_addr0", 32'(addr_log[0]), 32'h10);
        chk("fwd_addr1", 32'(addr_log[1]), 32'h11);
        chk("fwd_nsamp", 32'(samp_log.size()), 32'd4);
        chk("fwd_s0", 32'(samp_log[0]), 32'hAAAA);
        chk("fwd_s1", 32'(samp_log[1]), 32'hBBBB);
        chk("fwd_s2", 32'(samp_log[2]), 32'hCCCC);
        chk("fwd_s3", 32'(samp_log[3]), 32'hDDDD);
        chk("fwd_done", 32'(done_cnt), 32'd1);

        // Reverse
        clear_logs();
        do_start(23'h10, 23'h11, 1, 0);
        run_to_idle(8, 200);
        chk("rev_addr0", 32'(addr_log[0]), 32'h11);
        chk("rev_addr1", 32'(addr_log[1]), 32'h10);
        chk("rev_nsamp", 32'(samp_log.size()), 32'd4);
        chk("rev_s0", 32'(samp_log[0]), 32'hDDDD);
        chk("rev_s1", 32'(samp_log[1]), 32'hCCCC);
        chk("rev_s2", 32'(samp_log[2]), 32'hBBBB);
        chk("rev_s3", 32'(samp_log[3]), 32'hAAAA);
        chk("rev_done", 32'(done_cnt), 32'd1);

        // Waitrequest held for 5 cycles
        clear_logs();
        wr_hold = 5;
        do_start(23'h20, 23'h20, 0, 0);
        run_to_idle(8, 200);
        chk("wait_read_cycles", 32'(rd_cycles), 32'd6);
        chk("wait_done", 32'(done_cnt), 32'd1);

        // Single-word loop at the top of the address space
        clear_logs();
        do_start(23'h7FFFFF, 23'h7FFFFF, 0, 1);
        begin
            int c;
            c = 0;
            while (addr_log.size() < 3 && c < 300) begin
                tick_cycle(0, 0, (c % 4) == 3, 0);
                c++;
            end
        end
        chk("loop_nreads", 32'(addr_log.size() >= 3), 32'h1);
        chk("loop_addr0", 32'(addr_log[0]), 32'h7FFFFF);
        chk("loop_addr1", 32'(addr_log[1]), 32'h7FFFFF);
        chk("loop_addr2", 32'(addr_log[2]), 32'h7FFFFF);
        tick_cycle(0, 1, 0, 0);
        run_to_idle(4, 100);
        chk("loop_no_done", 32'(done_cnt), 32'd0);

        // Wrapped forward range
        clear_logs();
        do_start(23'h7FFFFF, 23'h000000, 0, 0);
        run_to_idle(8, 200);
        chk("wrap_addr0", 32'(addr_log[0]), 32'h7FFFFF);
        chk("wrap_addr1", 32'(addr_log[1]), 32'h000000);
        chk("wrap_done", 32'(done_cnt), 32'd1);

        // Tick during WAIT_DATA -> sticky underrun, audio unchanged
        clear_logs();
        lat_min = 3; lat_max = 3;
        do_start(23'h30, 23'h30, 0, 0);
        wait_accept(1, 50);
        a_before = audio_o;
        tick_cycle(0, 0, 1, 0);
        chk("underrun_set", 32'(under_o), 32'h1);
        chk("underrun_audio_held", 32'(audio_o), 32'(a_before));
        run_to_idle(4, 100);
        chk("underrun_sticky", 32'(under_o), 32'h1);
        do_start(23'h30, 23'h30, 0, 0);
        chk("underrun_cleared", 32'(under_o), 32'h0);
        run_to_idle(4, 100);

        // Abort in WAIT_DATA, data still returned
        clear_logs();
        do_start(23'h40, 23'h41, 0, 0);
        wait_accept(1, 50);
        tick_cycle(0, 1, 0, 0);
        run_to_idle(4, 50);
        chk("abort_no_valid", 32'(valid_cnt), 32'd0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Reset mid-REQ
        wr_hold = 10;
        do_start(23'h50, 23'h50, 0, 0);
        tick_cycle(0, 0, 0, 0);
        chk("rst_pre_read", 32'(read_o), 32'h1);
        tick_cycle(0, 0, 0, 1);
        chk("rst_read_cleared", 32'(read_o), 32'h0);
        chk("rst_busy_cleared", 32'(busy_o), 32'h0);
        wr_hold = 0;

        // Reset in WAIT_DATA, late readdatavalid lands in IDLE
        clear_logs();
        do_start(23'h60, 23'h60, 0, 0);
        wait_accept(1, 50);
        tick_cycle(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick_cycle(0, 0, 0, 0);
        chk("late_rdv_idle", 32'(busy_o), 32'h0);
        chk("late_rdv_no_valid", 32'(valid_cnt), 32'd0);

        // Randomized traffic
        rand_wr = 1'b1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            st = 0;
            if (!busy_o && $urandom_range(0, 5) == 0) begin
                st = 1;
                sa = AW'($urandom);
                if ($urandom_range(0, 3) == 0) sa = 23'h7FFFFE + AW'($urandom_range(0, 3));
                ea = sa + AW'($urandom_range(0, 3));
                dir = 1'($urandom_range(0, 1));
                loop_en = ($urandom_range(0, 5) == 0);
            end else if (busy_o && $urandom_range(0, 9) == 0) begin
                st = 1;
                sa = AW'($urandom); ea = AW'($urandom);
                dir = 1'($urandom_range(0, 1)); loop_en = 1'($urandom_range(0, 1));
            end
            ab = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 399) == 0);
            tk = ($urandom_range(0, 3) == 0);
            tick_cycle(st, ab, tk, rs);
        end
        tick_cycle(0, 0, 0, 1);
        tick_cycle(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_audio_streamer.md
FLASH_AUDIO_STREAMER -- requirements
Module: flash_audio_streamer

Interface
REQ-001 Parameter ADDR_W, default 23, flash word-address width.
REQ-002 Parameter DATA_W, default 32, flash read-data width.
REQ-003 Parameter SAMPLE_W, default 16, audio sample width; DATA_W/SAMPLE_W = N samples per word, N a power of 2, N >= 1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin playback of the range; ignored unless in IDLE.
REQ-008 abort  in  1  stop playback at the next safe point.
REQ-009 direction  in  1  0 = forward, 1 = reverse; latched at start.
REQ-010 loop_en  in  1  restart the range on completion; latched at start.
REQ-011 start_addr, end_addr  in  ADDR_W each  inclusive word range; latched at start.
REQ-012 sample_tick  in  1  single-cycle sample-rate strobe.
REQ-013 flash_mem_waitrequest, flash_mem_readdatavalid  in  1 each; flash_mem_readdata  in  DATA_W  Avalon-MM read slave response.
REQ-014 flash_mem_read  out  1; flash_mem_address  out  ADDR_W; flash_mem_write  out  1 (constant 0); flash_mem_writedata  out  DATA_W (constant 0); flash_mem_burstcount  out  6 (constant 1); flash_mem_byteenable  out  DATA_W/8 (constant all ones).
REQ-015 audio_out  out  SAMPLE_W  current sample, held between updates.
REQ-016 audio_valid  out  1  one-cycle pulse when audio_out updates.
REQ-017 busy  out  1  high in every state except IDLE; done  out  1  one-cycle pulse on normal completion; underrun  out  1  sticky missed-tick flag.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT_DATA, EMIT and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch the range, direction and loop_en, set addr to start_addr (forward) or end_addr (reverse), clear underrun, and go to REQ.
REQ-020 flash_mem_read SHALL be 1 only in REQ, with flash_mem_address = addr held stable, and the FSM SHALL stay in REQ while waitrequest=1.
REQ-021 In REQ, waitrequest=0 SHALL move the FSM to WAIT_DATA on the next edge.
REQ-022 In WAIT_DATA, readdatavalid=1 SHALL latch readdata into word_buf, set slice index to 0 (forward) or N-1 (reverse), and go to EMIT.
REQ-023 Slice k is readdata[(k+1)*SAMPLE_W-1 : k*SAMPLE_W]; slice 0 is the earliest sample in forward order.
REQ-024 In EMIT, each sample_tick SHALL load audio_out with slice index, pulse audio_valid on the following cycle, and step the index by +1 (forward) or -1 (reverse).
REQ-025 A tick on the last slice (N-1 forward, 0 reverse) SHALL end the word: if addr equals the terminal address (end_addr forward, start_addr reverse), go to REQ with addr reloaded when loop_en=1, else go to DONE; otherwise step addr by +/-1 modulo 2^ADDR_W and go to REQ.
REQ-026 Address stepping SHALL wrap (0x7FFFFF+1 = 0 at default width); start_addr > end_addr in forward mode is a legal wrapped range.
REQ-027 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-028 A sample_tick arriving in REQ or WAIT_DATA SHALL be dropped, SHALL NOT change audio_out, and SHALL set underrun.
REQ-029 An abort in IDLE SHALL have no effect.
REQ-030 An abort in EMIT SHALL move the FSM to IDLE on the next edge.
REQ-031 An abort in REQ or WAIT_DATA SHALL be held pending; the block SHALL complete the outstanding transfer, discard the data, and go to IDLE without asserting done or audio_valid.
REQ-032 A start asserted while busy=1 SHALL be ignored.
REQ-033 When abort and a last-slice tick coincide in EMIT, abort SHALL win: the sample is emitted and the FSM goes to IDLE, with no done pulse.
REQ-034 Range, direction and loop_en changes while busy SHALL have no effect until the next start.

Reset
REQ-035 rst=1 SHALL force IDLE and clear flash_mem_read, audio_out, audio_valid, busy, done, underrun, addr, slice index and abort_pending, overriding every other input including mid-transfer.
REQ-036 After reset, a late readdatavalid SHALL be ignored in IDLE.

Verification
REQ-037 Forward: range 0x10..0x11, readdata 0xBBBBAAAA then 0xDDDDCCCC, 4 ticks -> audio_out AAAA, BBBB, CCCC, DDDD, then one done pulse.
REQ-038 Reverse: same range and data -> flash addresses 0x11 then 0x10, samples DDDD, CCCC, BBBB, AAAA.
REQ-039 Waitrequest held high for 5 cycles -> read and address stable for all 5 cycles, no REQ exit.
REQ-040 Loop: single-word range 0x7FFFFF, loop_en=1 -> repeated reads at 0x7FFFFF and no done pulse; a forward range 0x7FFFFF..0x000000 -> addresses 0x7FFFFF then 0x000000.
REQ-041 Tick during WAIT_DATA -> underrun=1 and audio_out unchanged; underrun is cleared only by the next start.
REQ-042 Abort in WAIT_DATA followed by readdatavalid -> return to IDLE, no audio_valid and no done; rst asserted mid-REQ -> IDLE with read=0 on the next cycle.
